// File: rtl/note_tone_player.sv
// note_tone_player: plays a latched note command as a square wave
// for a timed number of ticks, with rests, octave shift and abort.
module note_tone_player #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NOTE_W  = 4,
  parameter int OCT_W   = 2,
  parameter int DUR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [NOTE_W-1:0] note,
  input  logic [OCT_W-1:0]  octave,
  input  logic [DUR_W-1:0]  duration,
  input  logic              stop,
  output logic              tone_out,
  output logic              tone_active,
  output logic              done
);

  localparam int TICK_RAW  = CLK_HZ / TICK_HZ;
  localparam int TICK_CYC  = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int PW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int HP_RAW    = CLK_HZ / (2 * 262);
  localparam int HP_MAX    = (HP_RAW < 1) ? 1 : HP_RAW;
  localparam int HW        = $clog2(HP_MAX + 1);
  localparam int NUM_TONES = 10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  function automatic logic [HW-1:0] hp_const(input int idx);
    int f;
    case (idx)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      6:       f = 494;
      7:       f = 523;
      8:       f = 587;
      9:       f = 659;
      default: f = 262;
    endcase
    return HW'(CLK_HZ / (2 * f));
  endfunction

  logic [0:0]       state;
  logic [HW-1:0]    hp_q;
  logic [HW-1:0]    tone_cnt;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] dur_cnt;
  logic             rest_q;

  logic [HW-1:0]    base_hp;
  logic [HW-1:0]    shifted_hp;
  logic [HW-1:0]    hp_sel;
  logic             rest_sel;
  logic             accept;
  logic             tick_wrap;
  logic             tone_wrap;
  logic             last_cycle;

  assign note_ready  = (state == IDLE);
  assign tone_active = (state == PLAY);
  assign accept      = note_valid && note_ready;
  assign tick_wrap   = (presc == PW'(TICK_CYC - 1));
  assign tone_wrap   = (tone_cnt == hp_q - HW'(1));
  assign last_cycle  = tick_wrap && (dur_cnt == DUR_W'(1));

  // Table lookup and octave shift of the incoming note, clamped to 1.
  always_comb begin
    base_hp  = '0;
    rest_sel = 1'b1;
    for (int i = 0; i < NUM_TONES; i++) begin
      if (int'(note) == i) begin
        base_hp  = hp_const(i);
        rest_sel = 1'b0;
      end
    end
    shifted_hp = base_hp >> octave;
    hp_sel     = (shifted_hp == '0) ? HW'(1) : shifted_hp;
  end

  // FSM, done pulse and latched command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      hp_q   <= HW'(1);
      rest_q <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (duration == '0) begin
              done <= 1'b1;
            end else begin
              state  <= PLAY;
              hp_q   <= hp_sel;
              rest_q <= rest_sel;
            end
          end
        end
        PLAY: begin
          if (stop) begin
            state <= IDLE;
          end else if (last_cycle) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tick prescaler and duration countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      dur_cnt <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        presc   <= '0;
        dur_cnt <= duration;
      end
    end else if (!stop && !last_cycle) begin
      if (tick_wrap) begin
        presc   <= '0;
        dur_cnt <= dur_cnt - DUR_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Half-period counter and square-wave output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt <= '0;
      tone_out <= 1'b0;
    end else if (state == IDLE) begin
      tone_out <= 1'b0;
      if (accept) begin
        tone_cnt <= '0;
      end
    end else if (stop || last_cycle) begin
      tone_out <= 1'b0;
    end else if (tone_wrap) begin
      tone_cnt <= '0;
      if (!rest_q) begin
        tone_out <= ~tone_out;
      end
    end else begin
      tone_cnt <= tone_cnt + HW'(1);
    end
  end

endmodule

// File: doc/note_tone_player.md
Name: note_tone_player

Overview:
- Parametrised successor to the combinational note-to-frequency encoder.
- Accepts a note command (note index, octave shift, duration) over a valid/ready handshake.
- Plays the note as a 50%-duty square wave for the requested duration, then signals completion.
- Sits between the song sequencer and the audio output pin/DAC driver.
- Supports octave shifting, rests, timed duration, abort, and back-to-back notes.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, duration tick rate. TICK_CYC = CLK_HZ/TICK_HZ, integer division, minimum 1.
- NOTE_W, 4, note index width.
- OCT_W, 2, octave shift width.
- DUR_W, 16, duration width, in ticks.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- note_valid  in  1  command valid.
- note_ready  out  1  block can accept a command.
- note  in  NOTE_W  note index.
- octave  in  OCT_W  upward octave shift (0 = base octave).
- duration  in  DUR_W  note length in ticks.
- stop  in  1  synchronous abort of the current note.
- tone_out  out  1  square-wave audio output.
- tone_active  out  1  high while a note or rest is playing.
- done  out  1  one-cycle pulse when a note or rest completes normally.

Behaviour:
- Reset values: state=IDLE, note_ready=1, tone_out=0, tone_active=0, done=0; all counters cleared. Reset overrides every other input, including mid-note.
- Base frequency table, indices 0..9 in Hz: 262, 294, 330, 349, 392, 440, 494, 523, 587, 659. Indices >=10 are rests: timed silence.
- Half-period table is elaboration-time constant: HP[i] = CLK_HZ/(2*f[i]), integer division.
- Runtime half-period = HP[note] >> octave. If the result is 0, use 1. No runtime divider.
- Command fields are latched on accept; inputs may change afterwards.
- FSM state IDLE:
  - note_ready=1.
  - Accept when note_valid && note_ready.
  - If duration==0: stay IDLE, pulse done next cycle, no tone.
  - Otherwise go to PLAY next cycle, clearing the tone counter and tick prescaler and loading the duration counter.
- FSM state PLAY:
  - note_ready=0, tone_active=1.
  - tone_out starts at 0. Tone counter counts 0..hp-1; tone_out toggles on the cycle the counter wraps, so each level lasts exactly hp cycles.
  - For a rest, tone_out stays 0.
  - Prescaler counts 0..TICK_CYC-1. On each wrap, the duration counter decrements.
  - PLAY lasts exactly duration*TICK_CYC cycles.
  - After the final PLAY cycle the block enters IDLE with done=1, tone_out=0, tone_active=0, note_ready=1 for that cycle.
- Back-to-back: a command presented in the done cycle is accepted. The next PLAY starts the following cycle, so there is a 1-cycle silent gap between notes.
- stop in PLAY: next cycle is IDLE with tone_out=0 and done=0. If note_valid is high in the same cycle as stop during PLAY, that command is ignored (note_ready=0).
- stop in IDLE: no effect. An accept in the same cycle still proceeds.
- done never asserts except on normal completion or a duration==0 accept.
- The duration counter is DUR_W wide, and the prescaler and tone counter are sized by $clog2 of their maxima. No wrap-around is possible for legal inputs.

Test Plan (CLK_HZ=10_000, TICK_HZ=1000 → TICK_CYC=10; HP table: 19,17,15,14,12,11,10,9,8,7):
- Reset check: assert reset for 3 cycles mid-PLAY → next cycle tone_out=0, tone_active=0, note_ready=1, done=0.
- Basic tone: note=5, octave=0, duration=4 → PLAY for 40 cycles; tone_out low 11 cycles, high 11, low 11, high 7; done pulses once at cycle 41; note_ready returns 1 in the same cycle.
- Octave shift and clamp:
  - note=5, octave=1 → 5-cycle half-period.
  - note=9, octave=3 → 7>>3=0, clamped to 1; tone_out toggles every cycle.
- Rest and zero duration:
  - note=12, duration=2 → tone_active=1 for 20 cycles, tone_out=0 throughout, then done.
  - duration=0 → no PLAY; done pulses the cycle after accept.
- Back-to-back: hold note_valid with note=0 then note=7, duration=1 each → second accept occurs in the done cycle; exactly 1 silent cycle between notes; two done pulses 11 cycles apart.
- Abort: stop after 15 cycles of a duration=5 note, with note_valid asserted in the same cycle → IDLE next cycle, tone_out=0, done never pulses, the concurrent command is not accepted, and a new command is accepted in the following cycle.
